// File: rtl/bootram_bus_ctrl.sv
// -----------------------------------------------------------------------------
// bootram_bus_ctrl
//
// Bridges the picorv32 native memory bus to four 2Kx8 boot RAM byte lanes.
// Lane i stores byte i of every 32-bit word, so together the lanes form an
// 8 KB word-organised boot RAM. A byte-wide loader port (UART/SPI boot loader)
// can also write the RAM and wins over the CPU whenever both ask at once.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb
//                         picorv32 request (wstrb == 0 means read)
//   mem_ready, mem_rdata  registered one-cycle completion pulse and read word
//   ld_valid/addr/data    loader byte write; ld_addr[1:0] selects the lane
//   ld_ready              loader byte accepted this cycle (combinational)
//   ram_reset, ram_oce    lane reset (follows reset) and output-register enable
//   ram_ce, ram_wre       per-lane clock enable / write enable
//   ram_ad, ram_din       shared word address and per-lane write bytes
//   ram_dout              per-lane read bytes, valid one cycle after ram_ce
// -----------------------------------------------------------------------------
module bootram_bus_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_BITS = 13,
    parameter bit          LD_ENABLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_valid,
    input  logic [31:0]          mem_addr,
    input  logic [31:0]          mem_wdata,
    input  logic [3:0]           mem_wstrb,
    output logic                 mem_ready,
    output logic [31:0]          mem_rdata,
    input  logic                 ld_valid,
    input  logic [ADDR_BITS-1:0] ld_addr,
    input  logic [7:0]           ld_data,
    output logic                 ld_ready,
    output logic                 ram_reset,
    output logic [3:0]           ram_ce,
    output logic                 ram_oce,
    output logic [3:0]           ram_wre,
    output logic [ADDR_BITS-3:0] ram_ad,
    output logic [31:0]          ram_din,
    input  logic [31:0]          ram_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       hit;
    logic       ld_req;
    logic [3:0] lane_onehot;

    // Accesses are word-aligned; byte selection comes from mem_wstrb alone.
    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr[1:0];

    assign hit         = mem_valid && (mem_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
    assign ld_req      = LD_ENABLE && ld_valid;
    assign lane_onehot = 4'b0001 << ld_addr[1:0];

    assign ram_reset = reset;
    assign ram_oce   = 1'b1;

    // NOTE: every output is given a default before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        ram_ce     = 4'h0;
        ram_wre    = 4'h0;
        ram_ad     = '0;
        ram_din    = 32'h0;
        // Strobes stay low in a reset cycle so a stale request never touches the RAM.
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (ld_req) begin
                        // Loader wins; a pending CPU hit just waits with mem_valid held.
                        ld_ready = 1'b1;
                        ram_ce   = lane_onehot;
                        ram_wre  = lane_onehot;
                        ram_ad   = ld_addr[ADDR_BITS-1:2];
                        ram_din  = {4{ld_data}};
                    end else if (hit) begin
                        ram_ad = mem_addr[ADDR_BITS-1:2];
                        if (mem_wstrb != 4'h0) begin
                            ram_ce     = mem_wstrb;
                            ram_wre    = mem_wstrb;
                            ram_din    = mem_wdata;
                            state_next = RESP;
                        end else begin
                            ram_ce     = 4'hF;
                            state_next = RD;
                        end
                    end
                end
                RD:      state_next = RESP;
                RESP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
        end else begin
            state <= state_next;
            // mem_ready is high exactly while the FSM sits in RESP.
            mem_ready <= (state_next == RESP);
            // The lanes present read data during RD (one cycle after ram_ce).
            if (state == RD) begin
                mem_rdata <= ram_dout;
            end
        end
    end

endmodule
